// File: rtl/sample_mgmt_mc.sv
// ---------------------------------------------------------------------------
// sample_mgmt_mc
//
// Sample acquisition manager. Per record it latches a source (ADC or UART
// FIFO), then repeatedly requests one raw sample, waits for its read strobe
// with a bounded timeout, and delivers the offset-corrected signed sample.
//
// Ports
//   i_clk, i_nrst            clock (rising edge), synchronous active-low reset
//   i_src                    source select (0 = ADC, 1 = FIFO), latched in INIT
//   i_enable                 allows new requests from IDLE
//   i_new_record             restart the record from INIT
//   i_convst_tick            ADC sample-rate tick
//   o_adc_convst             ADC conversion start (one cycle)
//   i_adc_busy, i_adc_rd_valid, i_adc_data    ADC status / data
//   o_fifo_req               FIFO read request (one cycle)
//   i_fifo_empty, i_fifo_rd_valid, i_fifo_data FIFO status / data
//   o_ecg_signal             converted sample (raw - DATA_OFFSET), held
//   o_ecg_signal_valid       one-cycle strobe for a new o_ecg_signal
//   o_ctr                    samples delivered in the current record
//   o_src_active             source latched for the current record
//   o_timeout                one-cycle pulse after a wait abort
//   o_err_cnt                saturating count of wait aborts
// ---------------------------------------------------------------------------
module sample_mgmt_mc #(
   parameter int DATA_WIDTH  = 11,
   parameter int CTR_WIDTH   = 24,
   parameter int TO_WIDTH    = 16,
   parameter int TO_CYCLES   = 5000,
   parameter int DATA_OFFSET = 1024,
   parameter int ERR_WIDTH   = 8
) (
   input  logic                         i_clk,
   input  logic                         i_nrst,
   input  logic                         i_src,
   input  logic                         i_enable,
   input  logic                         i_new_record,
   input  logic                         i_convst_tick,
   output logic                         o_adc_convst,
   input  logic                         i_adc_busy,
   input  logic                         i_adc_rd_valid,
   input  logic [DATA_WIDTH-1:0]        i_adc_data,
   output logic                         o_fifo_req,
   input  logic                         i_fifo_empty,
   input  logic                         i_fifo_rd_valid,
   input  logic [DATA_WIDTH-1:0]        i_fifo_data,
   output logic signed [DATA_WIDTH-1:0] o_ecg_signal,
   output logic                         o_ecg_signal_valid,
   output logic [CTR_WIDTH-1:0]         o_ctr,
   output logic                         o_src_active,
   output logic                         o_timeout,
   output logic [ERR_WIDTH-1:0]         o_err_cnt
);

   localparam logic [DATA_WIDTH-1:0] OFFSET   = DATA_WIDTH'(DATA_OFFSET);
   localparam logic [TO_WIDTH-1:0]   TO_LIMIT = TO_WIDTH'(TO_CYCLES);

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      SAMPLE_REQ,
      SAMPLE_WAIT,
      SAMPLE_VALID
   } state_t;

   state_t                  state_reg, state_next;
   logic                    src_reg, src_next;
   logic [CTR_WIDTH-1:0]    ctr_reg, ctr_next;
   logic [TO_WIDTH-1:0]     to_cnt_reg, to_cnt_next;
   logic [ERR_WIDTH-1:0]    err_reg, err_next;
   logic [DATA_WIDTH-1:0]   sig_reg, sig_next;
   logic                    timeout_reg, timeout_next;

   // Handshake signals of the latched source; the other source is ignored.
   logic                    sel_ready;
   logic                    sel_valid;
   logic [DATA_WIDTH-1:0]   sel_data;

   assign sel_ready = src_reg ? !i_fifo_empty : (i_convst_tick & !i_adc_busy);
   assign sel_valid = src_reg ? i_fifo_rd_valid : i_adc_rd_valid;
   assign sel_data  = src_reg ? i_fifo_data : i_adc_data;

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_reg   <= INIT;
         src_reg     <= 1'b0;
         ctr_reg     <= '0;
         to_cnt_reg  <= '0;
         err_reg     <= '0;
         sig_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         src_reg     <= src_next;
         ctr_reg     <= ctr_next;
         to_cnt_reg  <= to_cnt_next;
         err_reg     <= err_next;
         sig_reg     <= sig_next;
         timeout_reg <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      src_next     = src_reg;
      ctr_next     = ctr_reg;
      to_cnt_next  = to_cnt_reg;
      err_next     = err_reg;
      sig_next     = sig_reg;
      timeout_next = 1'b0;

      // A record restart beats everything in flight: no capture, no count,
      // no timeout accounting for the abandoned request.
      if (i_new_record) begin
         state_next = INIT;
      end else begin
         case (state_reg)
            INIT: begin
               src_next    = i_src;
               ctr_next    = '0;
               to_cnt_next = '0;
               state_next  = IDLE;
            end
            IDLE: begin
               if (i_enable && sel_ready) begin
                  state_next = SAMPLE_REQ;
               end
            end
            SAMPLE_REQ: begin
               to_cnt_next = '0;
               state_next  = SAMPLE_WAIT;
            end
            SAMPLE_WAIT: begin
               // Valid is tested first so a strobe arriving in the very cycle
               // the counter reaches the limit is still accepted.
               if (sel_valid) begin
                  sig_next   = sel_data - OFFSET;
                  ctr_next   = ctr_reg + CTR_WIDTH'(1);
                  state_next = SAMPLE_VALID;
               end else if ((to_cnt_reg + TO_WIDTH'(1)) == TO_LIMIT) begin
                  // Abort is registered: the pulse and the new error count
                  // appear together in the following IDLE cycle.
                  timeout_next = 1'b1;
                  to_cnt_next  = '0;
                  if (err_reg != '1) begin
                     err_next = err_reg + ERR_WIDTH'(1);
                  end
                  state_next = IDLE;
               end else begin
                  to_cnt_next = to_cnt_reg + TO_WIDTH'(1);
               end
            end
            SAMPLE_VALID: begin
               state_next = IDLE;
            end
            default: begin
               state_next = INIT;
            end
         endcase
      end
   end

   // Requests are pure decodes of the state register, so they are exactly
   // one cycle wide and cannot be affected by input glitches.
   assign o_adc_convst       = (state_reg == SAMPLE_REQ) && !src_reg;
   assign o_fifo_req         = (state_reg == SAMPLE_REQ) && src_reg;
   assign o_ecg_signal_valid = (state_reg == SAMPLE_VALID);
   assign o_ecg_signal       = sig_reg;
   assign o_ctr              = ctr_reg;
   assign o_src_active       = src_reg;
   assign o_timeout          = timeout_reg;
   assign o_err_cnt          = err_reg;

endmodule

// File: tb/tb_sample_mgmt_mc.sv
// ---------------------------------------------------------------------------
// tb_sample_mgmt_mc
//
// Bench for sample_mgmt_mc with small counters (CTR_WIDTH=4, TO_CYCLES=8).
// ADC and FIFO responders live in the per-cycle task; expected samples are
// pushed to a scoreboard when a read strobe is driven and popped when the
// design raises o_ecg_signal_valid.
// ---------------------------------------------------------------------------
module tb_sample_mgmt_mc;

   localparam int DW  = 11;
   localparam int CW  = 4;
   localparam int TW  = 16;
   localparam int TOC = 8;
   localparam int OFF = 1024;
   localparam int EW  = 8;

   logic           i_clk = 1'b0;
   logic           i_nrst;
   logic           i_src;
   logic           i_enable;
   logic           i_new_record;
   logic           i_convst_tick;
   logic           o_adc_convst;
   logic           i_adc_busy;
   logic           i_adc_rd_valid;
   logic [DW-1:0]  i_adc_data;
   logic           o_fifo_req;
   logic           i_fifo_empty;
   logic           i_fifo_rd_valid;
   logic [DW-1:0]  i_fifo_data;
   logic signed [DW-1:0] o_ecg_signal;
   logic           o_ecg_signal_valid;
   logic [CW-1:0]  o_ctr;
   logic           o_src_active;
   logic           o_timeout;
   logic [EW-1:0]  o_err_cnt;

   always #5 i_clk = ~i_clk;

   sample_mgmt_mc #(
      .DATA_WIDTH (DW),
      .CTR_WIDTH  (CW),
      .TO_WIDTH   (TW),
      .TO_CYCLES  (TOC),
      .DATA_OFFSET(OFF),
      .ERR_WIDTH  (EW)
   ) dut (
      .i_clk             (i_clk),
      .i_nrst            (i_nrst),
      .i_src             (i_src),
      .i_enable          (i_enable),
      .i_new_record      (i_new_record),
      .i_convst_tick     (i_convst_tick),
      .o_adc_convst      (o_adc_convst),
      .i_adc_busy        (i_adc_busy),
      .i_adc_rd_valid    (i_adc_rd_valid),
      .i_adc_data        (i_adc_data),
      .o_fifo_req        (o_fifo_req),
      .i_fifo_empty      (i_fifo_empty),
      .i_fifo_rd_valid   (i_fifo_rd_valid),
      .i_fifo_data       (i_fifo_data),
      .o_ecg_signal      (o_ecg_signal),
      .o_ecg_signal_valid(o_ecg_signal_valid),
      .o_ctr             (o_ctr),
      .o_src_active      (o_src_active),
      .o_timeout         (o_timeout),
      .o_err_cnt         (o_err_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // responder / stimulus state
   int            cyc = 0;
   int            tick_period = 0;
   int            tick_cnt = 0;
   logic          adc_respond = 1'b0;
   logic          adc_rand = 1'b0;
   int            adc_delay = 3;
   int            adc_cnt = 0;
   logic [DW-1:0] adc_raw = '0;
   logic [DW-1:0] fifo_q[$];
   int            fifo_cnt = 0;
   logic [DW-1:0] fifo_pend = '0;
   logic [DW-1:0] sb_q[$];
   logic          sb_push = 1'b1;
   int            last_rd_cyc = 0;

   // observations of the cycle that just ended at the falling edge
   logic          seen_convst, seen_req, seen_valid, seen_timeout;
   logic [DW-1:0] seen_sig;
   logic [CW-1:0] seen_ctr;
   logic [CW-1:0] exp_ctr = '0;
   logic [DW-1:0] exp_sig;

   // Advance one clock; sample at the falling edge, then drive this cycle's
   // responder inputs.
   task automatic cycle();
      logic [DW-1:0] raw;
      @(negedge i_clk);
      cyc++;
      seen_convst  = o_adc_convst;
      seen_req     = o_fifo_req;
      seen_valid   = o_ecg_signal_valid;
      seen_sig     = o_ecg_signal;
      seen_ctr     = o_ctr;
      seen_timeout = o_timeout;
      i_adc_rd_valid  = 1'b0;
      i_fifo_rd_valid = 1'b0;
      if (tick_period > 0) begin
         i_convst_tick = (tick_cnt == 0);
         tick_cnt = (tick_cnt == 0) ? tick_period - 1 : tick_cnt - 1;
      end else begin
         i_convst_tick = 1'b0;
      end
      if (adc_cnt > 0) begin
         adc_cnt--;
         if (adc_cnt == 0) begin
            raw = adc_rand ? DW'($urandom_range(0, 2047)) : adc_raw;
            i_adc_data     = raw;
            i_adc_rd_valid = 1'b1;
            last_rd_cyc    = cyc;
            if (sb_push) sb_q.push_back(raw - DW'(OFF));
         end
      end
      if (fifo_cnt > 0) begin
         fifo_cnt--;
         if (fifo_cnt == 0) begin
            i_fifo_data     = fifo_pend;
            i_fifo_rd_valid = 1'b1;
            last_rd_cyc     = cyc;
            if (sb_push) sb_q.push_back(fifo_pend - DW'(OFF));
         end
      end
      if (seen_convst && adc_respond) adc_cnt = adc_delay;
      if (seen_req && fifo_q.size() > 0) begin
         fifo_pend = fifo_q.pop_front();
         fifo_cnt  = 1;
      end
      i_fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic pulse_new_record(input logic src);
      i_src = src;
      i_new_record = 1'b1;
      cycle();
      i_new_record = 1'b0;
      cycle();
      cycle();
      exp_ctr = '0;
      sb_q.delete();
   endtask

   task automatic test_reset();
      i_nrst = 1'b0;
      cycle();
      cycle();
      n_tests++; if (o_ecg_signal !== '0)     begin n_fail++; $display("FAIL reset_sig: got %0h required 0", o_ecg_signal); end
      n_tests++; if (o_ecg_signal_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", o_ecg_signal_valid); end
      n_tests++; if (o_ctr !== '0)            begin n_fail++; $display("FAIL reset_ctr: got %0h required 0", o_ctr); end
      n_tests++; if (o_src_active !== 1'b0)   begin n_fail++; $display("FAIL reset_src: got %0b required 0", o_src_active); end
      n_tests++; if (o_timeout !== 1'b0)      begin n_fail++; $display("FAIL reset_timeout: got %0b required 0", o_timeout); end
      n_tests++; if (o_err_cnt !== '0)        begin n_fail++; $display("FAIL reset_err: got %0h required 0", o_err_cnt); end
      n_tests++; if (o_adc_convst !== 1'b0)   begin n_fail++; $display("FAIL reset_convst: got %0b required 0", o_adc_convst); end
      n_tests++; if (o_fifo_req !== 1'b0)     begin n_fail++; $display("FAIL reset_fifo_req: got %0b required 0", o_fifo_req); end
      i_nrst = 1'b1;
      i_src  = 1'b1;
      cycle();
      cycle();
      cycle();
      n_tests++; if (o_src_active !== 1'b1) begin n_fail++; $display("FAIL init_src_latch: got %0b required 1", o_src_active); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_adc();
      int n_conv = 0;
      int n_val  = 0;
      pulse_new_record(1'b0);
      adc_respond = 1'b1; adc_rand = 1'b0; adc_delay = 3; adc_raw = 11'h500;
      i_enable = 1'b1; tick_period = 100; tick_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         cycle();
         if (seen_convst) n_conv++;
         if (seen_valid) begin
            n_val++;
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++; $display("FAIL adc_unexpected_valid: got sig %0h, required no valid", seen_sig);
            end else begin
               exp_sig = sb_q.pop_front();
               if (seen_sig !== exp_sig) begin n_fail++; $display("FAIL adc_sig: got %0h required %0h", seen_sig, exp_sig); end
            end
            n_tests++; if (seen_sig !== 11'h100) begin n_fail++; $display("FAIL adc_sig_const: got %0h required 100", seen_sig); end
            n_tests++; if (cyc - last_rd_cyc != 1) begin n_fail++; $display("FAIL adc_latency: got %0d required 1", cyc - last_rd_cyc); end
            exp_ctr = exp_ctr + 1'b1;
            n_tests++; if (seen_ctr !== exp_ctr) begin n_fail++; $display("FAIL adc_ctr: got %0d required %0d", seen_ctr, exp_ctr); end
            $display("[TB] adc sample %0d sig=%0h ctr=%0d", n_val, seen_sig, seen_ctr);
         end
      end
      tick_period = 0;
      n_tests++; if (n_conv != 3) begin n_fail++; $display("FAIL adc_convst_count: got %0d required 3", n_conv); end
      n_tests++; if (n_val != 3)  begin n_fail++; $display("FAIL adc_valid_count: got %0d required 3", n_val); end
      n_tests++; if (o_src_active !== 1'b0) begin n_fail++; $display("FAIL adc_src_active: got %0b required 0", o_src_active); end
   endtask

   task automatic test_uart();
      int n_req = 0;
      int n_val = 0;
      int n_conv = 0;
      logic [DW-1:0] got[2];
      pulse_new_record(1'b1);
      i_enable = 1'b1; tick_period = 3; tick_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (seen_req) n_req++;
      end
      n_tests++; if (n_req != 0) begin n_fail++; $display("FAIL uart_req_while_empty: got %0d required 0", n_req); end
      fifo_q.push_back(11'h000);
      fifo_q.push_back(11'h7FF);
      i_fifo_empty = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (seen_req) n_req++;
         if (seen_convst) n_conv++;
         if (seen_valid) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++; $display("FAIL uart_unexpected_valid: got sig %0h, required no valid", seen_sig);
            end else begin
               exp_sig = sb_q.pop_front();
               if (seen_sig !== exp_sig) begin n_fail++; $display("FAIL uart_sig: got %0h required %0h", seen_sig, exp_sig); end
            end
            if (n_val < 2) got[n_val] = seen_sig;
            n_val++;
            exp_ctr = exp_ctr + 1'b1;
            n_tests++; if (seen_ctr !== exp_ctr) begin n_fail++; $display("FAIL uart_ctr: got %0d required %0d", seen_ctr, exp_ctr); end
            $display("[TB] uart sample %0d sig=%0h ctr=%0d", n_val, seen_sig, seen_ctr);
         end
      end
      tick_period = 0;
      n_tests++; if (n_req != 2)  begin n_fail++; $display("FAIL uart_req_count: got %0d required 2", n_req); end
      n_tests++; if (n_conv != 0) begin n_fail++; $display("FAIL uart_convst_count: got %0d required 0", n_conv); end
      n_tests++; if (n_val != 2)  begin n_fail++; $display("FAIL uart_valid_count: got %0d required 2", n_val); end
      if (n_val >= 2) begin
         n_tests++; if (got[0] !== 11'h400) begin n_fail++; $display("FAIL uart_min: got %0h required 400", got[0]); end
         n_tests++; if (got[1] !== 11'h3FF) begin n_fail++; $display("FAIL uart_max: got %0h required 3ff", got[1]); end
      end
      n_tests++; if (o_src_active !== 1'b1) begin n_fail++; $display("FAIL uart_src_active: got %0b required 1", o_src_active); end
   endtask

   task automatic test_timeout();
      int first_conv = -1;
      int first_to   = -1;
      int n_conv = 0;
      int n_to   = 0;
      int n_val  = 0;
      pulse_new_record(1'b0);
      adc_respond = 1'b0; i_enable = 1'b1; tick_period = 20; tick_cnt = 0;
      for (int i = 0; i < 45; i++) begin
         cycle();
         if (seen_convst) begin n_conv++; if (first_conv < 0) first_conv = cyc; end
         if (seen_valid) n_val++;
         if (seen_timeout) begin
            n_to++;
            if (first_to < 0) begin
               first_to = cyc;
               n_tests++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_err_first: got %0d required 1", o_err_cnt); end
            end
            $display("[TB] timeout %0d at cycle %0d err=%0d", n_to, cyc, o_err_cnt);
         end
      end
      tick_period = 0;
      n_tests++; if (first_to - first_conv != TOC + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d required %0d", first_to - first_conv, TOC + 1); end
      n_tests++; if (n_to != 2)   begin n_fail++; $display("FAIL timeout_count: got %0d required 2", n_to); end
      n_tests++; if (n_conv != 3) begin n_fail++; $display("FAIL timeout_next_req: got %0d required 3", n_conv); end
      n_tests++; if (n_val != 0)  begin n_fail++; $display("FAIL timeout_no_sample: got %0d required 0", n_val); end
      n_tests++; if (o_ctr !== '0) begin n_fail++; $display("FAIL timeout_ctr: got %0d required 0", o_ctr); end
      n_tests++; if (o_err_cnt !== 8'd2) begin n_fail++; $display("FAIL timeout_err: got %0d required 2", o_err_cnt); end
   endtask

   task automatic test_timeout_race();
      int n_to  = 0;
      int n_val = 0;
      pulse_new_record(1'b0);
      adc_respond = 1'b1; adc_delay = TOC; adc_raw = 11'h123;
      tick_period = 50; tick_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (seen_timeout) n_to++;
         if (seen_valid) begin
            n_val++;
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++; $display("FAIL race_unexpected_valid: got sig %0h, required no valid", seen_sig);
            end else begin
               exp_sig = sb_q.pop_front();
               if (seen_sig !== exp_sig) begin n_fail++; $display("FAIL race_sig: got %0h required %0h", seen_sig, exp_sig); end
            end
            exp_ctr = exp_ctr + 1'b1;
            n_tests++; if (seen_ctr !== exp_ctr) begin n_fail++; $display("FAIL race_ctr: got %0d required %0d", seen_ctr, exp_ctr); end
            $display("[TB] race sample sig=%0h ctr=%0d", seen_sig, seen_ctr);
         end
      end
      n_tests++; if (n_val != 1) begin n_fail++; $display("FAIL race_valid_count: got %0d required 1", n_val); end
      n_tests++; if (n_to != 0)  begin n_fail++; $display("FAIL race_timeout: got %0d required 0", n_to); end
      n_tests++; if (o_err_cnt !== 8'd2) begin n_fail++; $display("FAIL race_err_preserved: got %0d required 2", o_err_cnt); end
   endtask

   task automatic test_new_record();
      int n_val = 0;
      int n_to  = 0;
      logic found = 1'b0;
      adc_delay = 5; sb_push = 1'b0; tick_cnt = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (seen_convst) found = 1'b1;
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL newrec_convst: got none within 10 cycles required 1"); end
      cycle();
      i_src = 1'b1;
      i_new_record = 1'b1;
      cycle();
      i_new_record = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cycle();
         if (seen_valid) n_val++;
         if (seen_timeout) n_to++;
      end
      tick_period = 0;
      n_tests++; if (n_val != 0) begin n_fail++; $display("FAIL newrec_late_valid: got %0d required 0", n_val); end
      n_tests++; if (n_to != 0)  begin n_fail++; $display("FAIL newrec_timeout: got %0d required 0", n_to); end
      n_tests++; if (o_ctr !== '0) begin n_fail++; $display("FAIL newrec_ctr: got %0d required 0", o_ctr); end
      n_tests++; if (o_src_active !== 1'b1) begin n_fail++; $display("FAIL newrec_src: got %0b required 1", o_src_active); end
      n_tests++; if (o_err_cnt !== 8'd2) begin n_fail++; $display("FAIL newrec_err: got %0d required 2", o_err_cnt); end
      sb_push = 1'b1;
      $display("[TB] test_new_record done ctr=%0d src=%0b", o_ctr, o_src_active);
   endtask

   task automatic test_enable_pause();
      int n_val = 0;
      int n_conv = 0;
      logic found = 1'b0;
      pulse_new_record(1'b0);
      adc_delay = 3; adc_raw = 11'h0FF; i_enable = 1'b1; tick_period = 1; tick_cnt = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (seen_convst) found = 1'b1;
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL pause_convst: got none within 10 cycles required 1"); end
      i_enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (seen_convst) n_conv++;
         if (seen_valid) begin
            n_val++;
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++; $display("FAIL pause_unexpected_valid: got sig %0h, required no valid", seen_sig);
            end else begin
               exp_sig = sb_q.pop_front();
               if (seen_sig !== exp_sig) begin n_fail++; $display("FAIL pause_sig: got %0h required %0h", seen_sig, exp_sig); end
            end
            exp_ctr = exp_ctr + 1'b1;
            $display("[TB] pause sample sig=%0h ctr=%0d", seen_sig, seen_ctr);
         end
      end
      n_tests++; if (n_val != 1)  begin n_fail++; $display("FAIL pause_inflight_done: got %0d required 1", n_val); end
      n_tests++; if (n_conv != 0) begin n_fail++; $display("FAIL pause_blocked: got %0d required 0", n_conv); end
   endtask

   task automatic test_ctr_wrap();
      int n_val = 0;
      pulse_new_record(1'b0);
      adc_rand = 1'b1; i_enable = 1'b1; tick_period = 1; tick_cnt = 0;
      for (int i = 0; i < 400 && n_val < 16; i++) begin
         cycle();
         if (seen_valid) begin
            n_val++;
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++; $display("FAIL wrap_unexpected_valid: got sig %0h, required no valid", seen_sig);
            end else begin
               exp_sig = sb_q.pop_front();
               if (seen_sig !== exp_sig) begin n_fail++; $display("FAIL wrap_sig: got %0h required %0h", seen_sig, exp_sig); end
            end
            exp_ctr = exp_ctr + 1'b1;
            n_tests++; if (seen_ctr !== exp_ctr) begin n_fail++; $display("FAIL wrap_ctr: got %0d required %0d", seen_ctr, exp_ctr); end
            $display("[TB] wrap sample %0d sig=%0h ctr=%0d", n_val, seen_sig, seen_ctr);
            if (n_val == 16) i_enable = 1'b0;
         end
      end
      adc_rand = 1'b0;
      n_tests++; if (n_val != 16) begin n_fail++; $display("FAIL wrap_count: got %0d required 16", n_val); end
      n_tests++; if (o_ctr !== 4'd0) begin n_fail++; $display("FAIL wrap_to_zero: got %0d required 0", o_ctr); end
   endtask

   task automatic test_err_saturate();
      int n_to = 0;
      pulse_new_record(1'b0);
      adc_respond = 1'b0; i_enable = 1'b1; tick_period = 1; tick_cnt = 0;
      for (int i = 0; i < 4000 && n_to < 300; i++) begin
         cycle();
         if (seen_timeout) begin
            n_to++;
            if (n_to == 300) i_enable = 1'b0;
         end
      end
      $display("[TB] saturate timeouts=%0d err=%0d", n_to, o_err_cnt);
      n_tests++; if (n_to != 300) begin n_fail++; $display("FAIL sat_timeouts: got %0d required 300", n_to); end
      n_tests++; if (o_err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err: got %0d required 255", o_err_cnt); end
   endtask

   task automatic test_midreset();
      int n_val = 0;
      logic found = 1'b0;
      adc_respond = 1'b1; adc_delay = 3; adc_raw = 11'h600;
      i_enable = 1'b1; tick_period = 1; tick_cnt = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (seen_convst) found = 1'b1;
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL midrst_convst: got none within 10 cycles required 1"); end
      cycle();
      i_nrst = 1'b0;
      i_new_record = 1'b1;
      cycle();
      n_tests++; if (o_ctr !== '0)          begin n_fail++; $display("FAIL midrst_ctr: got %0d required 0", o_ctr); end
      n_tests++; if (o_err_cnt !== '0)      begin n_fail++; $display("FAIL midrst_err: got %0d required 0", o_err_cnt); end
      n_tests++; if (o_ecg_signal !== '0)   begin n_fail++; $display("FAIL midrst_sig: got %0h required 0", o_ecg_signal); end
      n_tests++; if (o_ecg_signal_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b required 0", o_ecg_signal_valid); end
      n_tests++; if (o_adc_convst !== 1'b0) begin n_fail++; $display("FAIL midrst_convst_low: got %0b required 0", o_adc_convst); end
      n_tests++; if (o_timeout !== 1'b0)    begin n_fail++; $display("FAIL midrst_timeout: got %0b required 0", o_timeout); end
      i_nrst = 1'b1;
      i_new_record = 1'b0;
      adc_cnt = 0;
      sb_q.delete();
      exp_ctr = '0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (seen_valid) begin
            n_val++;
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++; $display("FAIL midrst_unexpected_valid: got sig %0h, required no valid", seen_sig);
            end else begin
               exp_sig = sb_q.pop_front();
               if (seen_sig !== exp_sig) begin n_fail++; $display("FAIL midrst_sample: got %0h required %0h", seen_sig, exp_sig); end
            end
            exp_ctr = exp_ctr + 1'b1;
            n_tests++; if (seen_ctr !== exp_ctr) begin n_fail++; $display("FAIL midrst_restart_ctr: got %0d required %0d", seen_ctr, exp_ctr); end
            $display("[TB] post-reset sample %0d sig=%0h ctr=%0d", n_val, seen_sig, seen_ctr);
         end
      end
      i_enable = 1'b0;
      tick_period = 0;
      n_tests++; if (n_val < 1) begin n_fail++; $display("FAIL midrst_restart: got %0d samples required at least 1", n_val); end
      n_tests++; if (o_err_cnt !== '0) begin n_fail++; $display("FAIL midrst_err_after: got %0d required 0", o_err_cnt); end
   endtask

   initial begin
      i_nrst = 1'b0; i_src = 1'b0; i_enable = 1'b0; i_new_record = 1'b0;
      i_convst_tick = 1'b0; i_adc_busy = 1'b0; i_adc_rd_valid = 1'b0; i_adc_data = '0;
      i_fifo_empty = 1'b1; i_fifo_rd_valid = 1'b0; i_fifo_data = '0;
      test_reset();
      test_adc();
      test_uart();
      test_timeout();
      test_timeout_race();
      test_new_record();
      test_enable_pause();
      test_ctr_wrap();
      test_err_saturate();
      test_midreset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_mgmt_mc.md
SAMPLE_MGMT_MC -- requirements
Module: sample_mgmt_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, raw/signed sample width (>=4).
REQ-002 SHALL have parameter CTR_WIDTH, default 24, sample counter width.
REQ-003 SHALL have parameter TO_WIDTH, default 16, wait-timeout counter width.
REQ-004 SHALL have parameter TO_CYCLES, default 5000, cycles in SAMPLE_WAIT before abort (1..2^TO_WIDTH-1).
REQ-005 SHALL have parameter DATA_OFFSET, default 1024, offset subtracted from raw samples.
REQ-006 SHALL have parameter ERR_WIDTH, default 8, timeout error counter width.
REQ-007 i_clk  in  1  single clock; all logic rising-edge.
REQ-008 i_nrst  in  1  reset, synchronous and active-low.
REQ-009 i_src  in  1  source select: 0 = ADC, 1 = UART FIFO; sampled only at record start.
REQ-010 i_enable  in  1  1 = new requests allowed; 0 = pause after any in-flight sample.
REQ-011 i_new_record  in  1  single-cycle pulse: restart record.
REQ-012 i_convst_tick  in  1  ADC sample-rate tick (one cycle per sample period).
REQ-013 o_adc_convst  out  1  ADC conversion start pulse.
REQ-014 i_adc_busy / i_adc_rd_valid  in  1 each  ADC busy; ADC data valid strobe.
REQ-015 i_adc_data  in  DATA_WIDTH  ADC raw data.
REQ-016 o_fifo_req  out  1  FIFO read request pulse.
REQ-017 i_fifo_empty / i_fifo_rd_valid  in  1 each  FIFO empty; FIFO read-data valid.
REQ-018 i_fifo_data  in  DATA_WIDTH  FIFO raw data.
REQ-019 o_ecg_signal  out  DATA_WIDTH signed  converted sample.
REQ-020 o_ecg_signal_valid  out  1  one-cycle strobe, o_ecg_signal new.
REQ-021 o_ctr  out  CTR_WIDTH  samples delivered in current record.
REQ-022 o_src_active  out  1  source latched for current record.
REQ-023 o_timeout  out  1  one-cycle pulse on wait abort.
REQ-024 o_err_cnt  out  ERR_WIDTH  saturating timeout count.

Function
REQ-025 FSM states INIT, IDLE, SAMPLE_REQ, SAMPLE_WAIT, SAMPLE_VALID; state register is the only driver of request outputs.
REQ-026 INIT: latch i_src into o_src_active, clear o_ctr and timeout counter; next IDLE unconditionally.
REQ-027 IDLE -> SAMPLE_REQ when i_enable and ready; ADC ready = i_convst_tick & !i_adc_busy; UART ready = !i_fifo_empty; else stay.
REQ-028 SAMPLE_REQ lasts exactly one cycle; o_adc_convst (ADC) or o_fifo_req (UART) SHALL be high exactly in that cycle, the other request low; next SAMPLE_WAIT.
REQ-029 SAMPLE_WAIT: on selected source rd_valid, capture data and go SAMPLE_VALID; unselected source strobes ignored.
REQ-030 SAMPLE_WAIT timeout counter increments each cycle; on reaching TO_CYCLES without valid: pulse o_timeout, o_err_cnt +1 (saturate at all-ones), go IDLE, no sample, o_ctr unchanged.
REQ-031 rd_valid in the same cycle the counter reaches TO_CYCLES SHALL win: sample accepted, no timeout.
REQ-032 SAMPLE_VALID: o_ecg_signal_valid high this cycle, o_ctr +1 (wraps to 0 at all-ones); next IDLE; latency valid-strobe-in to valid-out = 1 cycle.
REQ-033 Conversion: o_ecg_signal = (raw - DATA_OFFSET) truncated to DATA_WIDTH, two's complement; held between samples.
REQ-034 i_new_record in any state SHALL force INIT next cycle, abort in-flight sample (late rd_valid discarded), not count a timeout; o_err_cnt preserved.
REQ-035 i_enable low SHALL not abort SAMPLE_REQ/WAIT/VALID; only blocks IDLE -> SAMPLE_REQ.
REQ-036 i_src changes outside INIT SHALL have no effect until next record.

Reset
REQ-037 On i_clk edge with i_nrst=0: state INIT, all outputs 0 (o_ecg_signal, valid, o_ctr, o_src_active, o_timeout, o_err_cnt, both requests), timeout counter 0.
REQ-038 Reset SHALL override i_new_record and any in-flight handshake.

Verification
REQ-039 ADC, src=0, enable=1, tick every 100 cycles, rd_valid 3 cycles after convst, raw 0x500 -> one convst per tick, o_ecg_signal=0x100 (+256), o_ctr 1,2,3...
REQ-040 UART, src=1, FIFO holds 0x000, 0x7FF -> outputs 0x400 (-1024), 0x3FF (+1023), o_fifo_req one cycle each, none while empty.
REQ-041 Timeout, TO_CYCLES=8, rd_valid never returns -> o_timeout at 8th wait cycle, o_err_cnt=1, o_ctr unchanged, next request issued.
REQ-042 i_new_record mid SAMPLE_WAIT with i_src toggled, then late rd_valid -> no valid output, o_ctr=0, o_src_active = new i_src.
REQ-043 o_err_cnt after 300 timeouts (ERR_WIDTH=8) = 255; o_ctr wrap with CTR_WIDTH=4: 16th sample -> 0.
REQ-044 Mid-operation i_nrst=0 for one cycle -> all outputs 0 next edge, FSM restarts via INIT.
